rate_mult_decoder: RTL and testbench

//  Receive-side counterpart of the team's binary rate-multiplier (fractional multiplier) pulse generator.

---
 rtl/rate_mult_decoder.sv | 147 ++++++++++++++
 tb/tb_rate_mult_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rate_mult_decoder.sv
// Receive-side decoder for the binary rate-multiplier pulse stream: tracks the 2^W-sample frame
// from a sync strobe and recovers the (W+1)-bit coefficient, pulse total and a consistency flag.
module rate_mult_decoder #(
   parameter int W = 8
) (
   input  logic         blif_clk_net,
   input  logic         blif_reset_net,
   input  logic         p_en,
   input  logic         frame_sync,
   input  logic         z_in,
   output logic [W:0]   c_out,
   output logic         c_valid,
   output logic         c_err,
   output logic [W:0]   ones_cnt,
   output logic         locked
);

   localparam int SW = $clog2(W + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t         r_state, w_state_next;
   logic [W-1:0]   r_cnt, w_cnt_next;
   logic [W:0]     r_seen, w_seen_next, w_seen_s;
   logic [W:0]     r_val, w_val_next, w_val_s;
   logic [W:0]     r_acc, w_acc_next, w_acc_s;
   logic           r_err_acc, w_err_next, w_err_s;
   logic [W:0]     r_c_out, w_c_out_next;
   logic [W:0]     r_ones, w_ones_next;
   logic           r_c_err, w_c_err_next;
   logic           r_c_valid, w_c_valid_next;
   logic [SW-1:0]  w_slot;
   logic           w_frame_end;

   // Slot = trailing ones of cnt, i.e. position of the lowest zero; all-ones maps to slot W.
   always_comb begin
      w_slot = SW'(W);
      for (int i = W - 1; i >= 0; i--) begin
         if (!r_cnt[i]) w_slot = SW'(i);
      end
   end

   assign w_frame_end = p_en && (&r_cnt);

   // Frame accumulators as they would look after absorbing this cycle's input.
   always_comb begin
      w_seen_s = r_seen;
      w_val_s  = r_val;
      w_err_s  = r_err_acc;
      if (p_en) begin
         if (!r_seen[w_slot]) begin
            w_val_s[w_slot]  = z_in;
            w_seen_s[w_slot] = 1'b1;
         end else if (r_val[w_slot] != z_in) begin
            w_err_s = 1'b1;
         end
      end else if (z_in) begin
         w_err_s = 1'b1;
      end
      w_acc_s = r_acc + {{W{1'b0}}, p_en & z_in};
   end

   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_seen_next    = r_seen;
      w_val_next     = r_val;
      w_acc_next     = r_acc;
      w_err_next     = r_err_acc;
      w_c_out_next   = r_c_out;
      w_ones_next    = r_ones;
      w_c_err_next   = r_c_err;
      w_c_valid_next = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (frame_sync) begin
               w_state_next = S_RUN;
               w_cnt_next   = '0;
               w_seen_next  = '0;
               w_val_next   = '0;
               w_acc_next   = '0;
               w_err_next   = 1'b0;
            end
         end
         S_RUN: begin
            if (w_frame_end) begin
               // Closing sample wins over a coincident sync; both restart at n=0 anyway.
               w_c_valid_next = 1'b1;
               w_c_out_next   = w_val_s;
               w_ones_next    = w_acc_s;
               w_c_err_next   = w_err_s;
               w_cnt_next     = '0;
               w_seen_next    = '0;
               w_val_next     = '0;
               w_acc_next     = '0;
               w_err_next     = 1'b0;
            end else if (frame_sync) begin
               w_cnt_next  = '0;
               w_seen_next = '0;
               w_val_next  = '0;
               w_acc_next  = '0;
               w_err_next  = 1'b0;
            end else begin
               w_cnt_next  = r_cnt + {{(W-1){1'b0}}, p_en};
               w_seen_next = w_seen_s;
               w_val_next  = w_val_s;
               w_acc_next  = w_acc_s;
               w_err_next  = w_err_s;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge blif_clk_net) begin
      if (blif_reset_net) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_seen    <= '0;
         r_val     <= '0;
         r_acc     <= '0;
         r_err_acc <= 1'b0;
         r_c_out   <= '0;
         r_ones    <= '0;
         r_c_err   <= 1'b0;
         r_c_valid <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_seen    <= w_seen_next;
         r_val     <= w_val_next;
         r_acc     <= w_acc_next;
         r_err_acc <= w_err_next;
         r_c_out   <= w_c_out_next;
         r_ones    <= w_ones_next;
         r_c_err   <= w_c_err_next;
         r_c_valid <= w_c_valid_next;
      end
   end

   assign c_out    = r_c_out;
   assign c_valid  = r_c_valid;
   assign c_err    = r_c_err;
   assign ones_cnt = r_ones;
   assign locked   = (r_state == S_RUN);

endmodule

// File: tb/tb_rate_mult_decoder.sv
// Randomized bench for rate_mult_decoder: a pulse generator drives frames and a frame-level
// reference model predicts every output on every cycle.
module tb_rate_mult_decoder;

   localparam int W = 8;
   localparam int N = 1 << W;

   logic         clk = 1'b0;
   logic         rst, sync, pen, z;
   logic [W:0]   c_out, ones_cnt;
   logic         c_valid, c_err, locked;

   int vectors     = 0;
   int miscompares = 0;

   bit          m_run;
   bit          m_q[$];
   bit          m_viol;
   logic [W:0]  m_c, m_ones;
   logic        m_err, m_valid;

   always #5 clk = ~clk;

   rate_mult_decoder #(.W(W)) dut (
      .blif_clk_net   (clk),
      .blif_reset_net (rst),
      .p_en           (pen),
      .frame_sync     (sync),
      .z_in           (z),
      .c_out          (c_out),
      .c_valid        (c_valid),
      .c_err          (c_err),
      .ones_cnt       (ones_cnt),
      .locked         (locked)
   );

   function automatic int slot_of(input int n);
      int k = 0;
      int m = n;
      while ((m % 2 == 1) && (k < W)) begin
         m = m / 2;
         k++;
      end
      return k;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic clear_frame();
      m_q.delete();
      m_viol = 1'b0;
   endtask

   // Recovered word = first value seen per slot; any later disagreement or stray pulse flags error.
   task automatic close_frame();
      logic [W:0] c;
      bit         got_slot [W+1];
      bit         err;
      int         ones;
      c = '0;
      err = m_viol;
      ones = 0;
      for (int k = 0; k <= W; k++) got_slot[k] = 1'b0;
      for (int i = 0; i < N; i++) begin
         int k;
         k = slot_of(i);
         ones += int'(m_q[i]);
         if (!got_slot[k]) begin
            c[k] = m_q[i];
            got_slot[k] = 1'b1;
         end else if (c[k] != m_q[i]) begin
            err = 1'b1;
         end
      end
      m_c     = c;
      m_ones  = (W+1)'(ones);
      m_err   = err;
      m_valid = 1'b1;
      clear_frame();
   endtask

   task automatic model_step(input bit r, input bit s, input bit p, input bit zz);
      m_valid = 1'b0;
      if (r) begin
         m_run = 1'b0;
         clear_frame();
         m_c = '0;
         m_ones = '0;
         m_err = 1'b0;
      end else if (!m_run) begin
         if (s) begin
            m_run = 1'b1;
            clear_frame();
         end
      end else if (p && m_q.size() == N - 1) begin
         m_q.push_back(zz);
         close_frame();
      end else if (s) begin
         clear_frame();
      end else if (p) begin
         m_q.push_back(zz);
      end else if (zz) begin
         m_viol = 1'b1;
      end
   endtask

   task automatic cycle(input bit r, input bit s, input bit p, input bit zz);
      rst = r; sync = s; pen = p; z = zz;
      @(posedge clk);
      model_step(r, s, p, zz);
      #1;
      check("c_valid", 32'(c_valid), 32'(m_valid));
      check("locked", 32'(locked), 32'(m_run));
      check("c_out", 32'(c_out), 32'(m_c));
      check("ones_cnt", 32'(ones_cnt), 32'(m_ones));
      check("c_err", 32'(c_err), 32'(m_err));
      if (m_valid)
         $display("frame done: c_out=%03h ones_cnt=%0d c_err=%0d", c_out, ones_cnt, c_err);
   endtask

   // One generator frame; fault_n flips that sample, abort_n sends sync, rst_n asserts reset.
   task automatic gen_frame(input logic [W:0] c, input int pen_pct, input int fault_n,
                            input int abort_n, input int rst_n, input bit sync_last, input bit noise);
      int n = 0;
      while (n < N) begin
         if ($urandom_range(99) < pen_pct) begin
            bit zz;
            zz = c[slot_of(n)];
            if (n == fault_n) zz = ~zz;
            if (n == rst_n) begin
               cycle(1'b1, 1'b0, 1'b1, zz);
               return;
            end
            if (n == abort_n) begin
               cycle(1'b0, 1'b1, 1'b1, zz);
               return;
            end
            cycle(1'b0, sync_last && (n == N - 1), 1'b1, zz);
            n++;
         end else begin
            cycle(1'b0, 1'b0, 1'b0, noise && ($urandom_range(19) == 0));
         end
      end
   endtask

   initial begin
      logic [W:0] rc;
      m_run = 1'b0; m_viol = 1'b0; m_c = '0; m_ones = '0; m_err = 1'b0; m_valid = 1'b0;
      rst = 1'b1; sync = 1'b0; pen = 1'b0; z = 1'b0;
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);

      gen_frame(9'h1FF, 100, -1, -1, -1, 1'b0, 1'b0);
      gen_frame(9'h101, 100, -1, -1, -1, 1'b0, 1'b0);
      gen_frame(9'h100, 100, -1, -1, -1, 1'b0, 1'b0);
      gen_frame(9'h000, 100, -1, -1, -1, 1'b0, 1'b0);
      gen_frame(9'h004, 50, -1, -1, -1, 1'b0, 1'b0);
      gen_frame(9'h001, 100, 64, -1, -1, 1'b0, 1'b0);
      gen_frame(9'h001, 100, -1, -1, -1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);

      rc = 9'($urandom);
      gen_frame(rc, 100, -1, 100, -1, 1'b0, 1'b0);
      gen_frame(rc, 100, -1, -1, -1, 1'b1, 1'b0);

      for (int f = 0; f < 4; f++) begin
         rc = 9'($urandom);
         gen_frame(rc, $urandom_range(100, 30), -1, -1, -1, 1'($urandom_range(1)), f == 2);
      end

      gen_frame(9'($urandom), 100, -1, -1, 200, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++)
         cycle(1'b0, 1'b0, 1'b1, 1'($urandom_range(1)));
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int f = 0; f < 2; f++)
         gen_frame(9'($urandom), 80, -1, -1, -1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
